// File: rtl/interval_timer_if.sv
// Control/status bundle for interval_timer.
//   master: drives start/stop/periodic/period/prescale, observes val/busy/tick/done.
//   slave : the timer itself.
interface interval_timer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] val;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output start, stop, periodic, period, prescale,
    input  val, busy, tick, done
  );

  modport slave (
    input  start, stop, periodic, period, prescale,
    output val, busy, tick, done
  );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: a prescaled up-counter that wraps at the latched
// period, emitting a one-cycle tick per wrap and, in one-shot mode, a done pulse.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - interval_timer_if.slave: start/stop/periodic/period/prescale in,
//           val/busy/tick/done out (all outputs registered)
module interval_timer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  interval_timer_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [WIDTH-1:0] ValOne = WIDTH'(1);
  localparam logic [PRE_W-1:0] PreOne = PRE_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             periodic_q, periodic_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             start_ok;

  // A zero period is illegal; such a start is simply dropped.
  assign start_ok = bus.start && (bus.period != '0);

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    pre_d      = pre_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok && !bus.stop) begin
          state_d    = StRun;
          val_d      = '0;
          pre_d      = '0;
          period_d   = bus.period;
          prescale_d = bus.prescale;
          periodic_d = bus.periodic;
        end
      end
      StRun: begin
        if (bus.stop) begin
          // Abort suppresses any coinciding terminal count.
          state_d = StIdle;
          val_d   = '0;
          pre_d   = '0;
        end else if (start_ok) begin
          // Restart: relatch and begin a fresh interval, no tick from the old one.
          val_d      = '0;
          pre_d      = '0;
          period_d   = bus.period;
          prescale_d = bus.prescale;
          periodic_d = bus.periodic;
        end else if (pre_q == prescale_q) begin
          pre_d = '0;
          // period_q is never 0 in StRun, so period_q - 1 cannot underflow.
          if (val_q == period_q - ValOne) begin
            val_d  = '0;
            tick_d = 1'b1;
            if (!periodic_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            val_d = val_q + ValOne;
          end
        end else begin
          pre_d = pre_q + PreOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      val_q      <= '0;
      pre_q      <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      pre_q      <= pre_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

  assign bus.val  = val_q;
  assign bus.busy = (state_q == StRun);
  assign bus.tick = tick_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer; expected values are hand-derived.
module tb_interval_timer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned PRE_W = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  interval_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) tif ();

  interval_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sit 1ns past it for sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [WIDTH-1:0] v, input logic b,
                         input logic t, input logic d);
    chk({tag, ".val"},  32'(tif.val),  32'(v));
    chk({tag, ".busy"}, 32'(tif.busy), 32'(b));
    chk({tag, ".tick"}, 32'(tif.tick), 32'(t));
    chk({tag, ".done"}, 32'(tif.done), 32'(d));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset        = 1'b0;
    tif.start    = 1'b0;
    tif.stop     = 1'b0;
    tif.periodic = 1'b0;
    tif.period   = '0;
    tif.prescale = '0;
    #12;
    chk_out("por", 16'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();

    // Asynchronous reset mid-run at val=4.
    tif.period = 16'd10; tif.prescale = 8'd0; tif.periodic = 1'b1; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_out("pre_rst", 16'd4, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_out("async_rst", 16'd0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_out("post_rst_idle", 16'd0, 1'b0, 1'b0, 1'b0);

    // One-shot, period 3, prescale 0.
    tif.period = 16'd3; tif.prescale = 8'd0; tif.periodic = 1'b0; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    chk_out("os_e0", 16'd0, 1'b1, 1'b0, 1'b0);
    step(); chk_out("os_e1", 16'd1, 1'b1, 1'b0, 1'b0);
    step(); chk_out("os_e2", 16'd2, 1'b1, 1'b0, 1'b0);
    step(); chk_out("os_e3", 16'd0, 1'b0, 1'b1, 1'b1);
    step(); chk_out("os_e4", 16'd0, 1'b0, 1'b0, 1'b0);

    // Periodic, period 4, prescale 1: tick every 8 edges; input changes ignored.
    tif.period = 16'd4; tif.prescale = 8'd1; tif.periodic = 1'b1; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    tif.period = 16'd7; tif.prescale = 8'd0; tif.periodic = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int e = 1; e <= 8; e++) begin
        step();
        chk("per.tick", 32'(tif.tick), (e == 8) ? 32'd1 : 32'd0);
        chk("per.busy", 32'(tif.busy), 32'd1);
        chk("per.done", 32'(tif.done), 32'd0);
        chk("per.val", 32'(tif.val), 32'((e / 2) % 4));
      end
    end
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    chk_out("per_stop", 16'd0, 1'b0, 1'b0, 1'b0);

    // Stop coinciding with terminal count, period 2.
    tif.period = 16'd2; tif.prescale = 8'd0; tif.periodic = 1'b0; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    step(); chk_out("stc_e1", 16'd1, 1'b1, 1'b0, 1'b0);
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    chk_out("stc_stop", 16'd0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("stc_after", 16'd0, 1'b0, 1'b0, 1'b0);

    // start with period 0 is ignored.
    tif.period = 16'd0; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    chk_out("p0_start", 16'd0, 1'b0, 1'b0, 1'b0);
    step(); chk_out("p0_after", 16'd0, 1'b0, 1'b0, 1'b0);

    // Restart in RUN: period 5 at val 3, restart with period 2.
    tif.period = 16'd5; tif.prescale = 8'd0; tif.periodic = 1'b0; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_out("rs_v3", 16'd3, 1'b1, 1'b0, 1'b0);
    tif.period = 16'd2; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    chk_out("rs_restart", 16'd0, 1'b1, 1'b0, 1'b0);
    step(); chk_out("rs_e1", 16'd1, 1'b1, 1'b0, 1'b0);
    step(); chk_out("rs_e2", 16'd0, 1'b0, 1'b1, 1'b1);

    // start and stop together from IDLE.
    tif.period = 16'd4; tif.start = 1'b1; tif.stop = 1'b1;
    step();
    tif.start = 1'b0; tif.stop = 1'b0;
    chk_out("ss_idle", 16'd0, 1'b0, 1'b0, 1'b0);

    // period 1, prescale 2, periodic: tick every 3 edges, val stays 0.
    tif.period = 16'd1; tif.prescale = 8'd2; tif.periodic = 1'b1; tif.start = 1'b1;
    step();
    tif.start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int e = 1; e <= 3; e++) begin
        step();
        chk("p1.tick", 32'(tif.tick), (e == 3) ? 32'd1 : 32'd0);
        chk("p1.val", 32'(tif.val), 32'd0);
        chk("p1.busy", 32'(tif.busy), 32'd1);
      end
    end
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    chk_out("p1_stop", 16'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Controller that sequences a free-running up-counter into a programmable interval timer.
- Supports one-shot and periodic modes, a clock prescaler, and a registered terminal-count pulse.
- Sits between control logic (or a register interface) and consumers needing periodic strobes, e.g. pixel/line pacing and SRAM refresh pacing.
- All run-time settings are latched on start, so the controller never sees mid-interval changes.

Parameters:
- WIDTH, 16, width of the interval counter and the period input.
- PRE_W, 8, width of the prescaler counter and the prescale input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: asserting (0) clears state immediately; deassertion is synchronous to clk upstream.
- start  input  1  single-cycle request to begin (or restart) an interval.
- stop  input  1  single-cycle request to abort; has priority over start.
- periodic  input  1  mode, latched at start: 1 = auto-reload, 0 = one-shot.
- period  input  WIDTH  interval length in prescaled ticks, latched at start; 0 is illegal and start is ignored.
- prescale  input  PRE_W  divider minus one, latched at start; 0 means count every clk.
- val  output  WIDTH  current interval count, 0..period-1.
- busy  output  1  high while in RUN.
- tick  output  1  one-cycle pulse at each terminal count.
- done  output  1  one-cycle pulse when a one-shot interval completes.

Behaviour:
- Reset (reset=0): state=IDLE; val, prescaler, busy, tick, done = 0; latched period/prescale/mode = 0. This applies in any state, mid-interval included, and takes effect without a clock edge.
- All outputs are registered. tick and done are high for exactly one cycle.
- States: IDLE, RUN.
- IDLE, start=1, stop=0, period!=0: latch period, prescale and periodic; clear val and prescaler. Next cycle: busy=1, val=0.
- IDLE, start=1, period=0: ignored; state stays IDLE, no outputs change.
- RUN, each edge:
  - If prescaler == latched prescale: prescaler becomes 0 and val advances. Otherwise prescaler increments and val holds.
  - Advance with val == period-1: val becomes 0 and tick=1 next cycle.
  - On that wrap in one-shot mode: also done=1, busy=0, state goes to IDLE.
  - On that wrap in periodic mode: stay in RUN.
  - Any other advance: val+1.
- Latency: with prescale=0, the first tick appears P edges after the edge that sampled start. In general this is P*(prescale+1) edges.
- stop=1 in RUN: go to IDLE, clear val and prescaler, busy=0. No tick or done that cycle, even if a terminal count coincides. stop in IDLE is a no-op.
- start=1 and stop=1 together: stop wins. From IDLE, nothing happens.
- start=1 in RUN (stop=0): restart. Relatch all settings and clear val/prescaler. No tick is generated, even if a terminal count coincides. busy stays 1.
- Changes to period, prescale or periodic during RUN have no effect until the next start.
- period=1: val stays 0 and tick fires every (prescale+1) edges.
- Maximum values (period=2^WIDTH-1, prescale=2^PRE_W-1) must not overflow. All comparisons are at full width with no wrap past period-1.

Test Plan:
- Reset to 0 mid-run (period=10, val=4) -> all outputs 0 immediately, before the next clk edge. After reset=1, state stays IDLE until start.
- One-shot, period=3, prescale=0, start at edge0:
  - val reads 1 at edge1, 2 at edge2, 0 at edge3.
  - tick=1 and done=1 after edge3, busy=0 after edge3; both pulses low after edge4.
- Periodic, period=4, prescale=1: tick every 8 edges, repeated 3 times. busy stays 1 throughout and done never asserts.
- stop coinciding with terminal count (period=2): no tick, no done, val=0, busy=0. Also, start=1 with period=0 is ignored: busy stays 0.
- Restart in RUN: period=5 running at val=3, assert start with period=2 -> val=0, then tick 2 edges later. No tick is emitted from the aborted interval.
- start and stop asserted together from IDLE -> busy remains 0 and val=0. Then period=1, prescale=2 periodic -> tick every 3 edges with val constant 0.
